vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Pixel-rate raster timing generator for the Pano G1 video path.
- Sits directly upstream of the sprite/pattern renderers such as the bouncing-ghost effect.
- Produces stage-0 pixel coordinates plus per-line and per-frame strobes.
- Produces hsync/vsync/blank_n delayed by PIPE pixel cycles, so a renderer with PIPE cycles of latency lines up with the sync pulses at the DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch
- HSYNC_POL, 0, asserted level of hsync (0 = active low)
- VSYNC_POL, 0, asserted level of vsync
- PIPE, 2, delay in ce-cycles from coordinates to sync/blank outputs (range 1..8)

Ports:
- clk  in  1  pixel clock (25 MHz BUFG'd clock)
- rst  in  1  synchronous reset, active high
- ce  in  1  pixel enable; all state advances only when high
- hc  out  10  horizontal counter, stage 0
- vc  out  10  vertical counter, stage 0
- active  out  1  stage-0 visible flag: hc<H_ACTIVE && vc<V_ACTIVE
- line_start  out  1  one-clock strobe for hc==0
- frame_start  out  1  one-clock strobe for hc==0, vc==0
- vblank_start  out  1  one-clock strobe for hc==0, vc==V_ACTIVE (sprite-update tick)
- hsync  out  1  delayed PIPE stages
- vsync  out  1  delayed PIPE stages
- blank_n  out  1  delayed active, PIPE stages

Behaviour:
- Derived totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525). Counters are 10 bits wide.
- On a ce cycle:
  - hc increments.
  - hc==H_TOTAL-1 → hc=0 and vc increments.
  - vc==V_TOTAL-1 at end of line → vc=0.
- No state change when ce=0; all outputs hold their values.
- Sync decode at stage 0:
  - hs0 is true for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vs0 is true for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
  - hsync/vsync pin level = asserted ? POL : ~POL.
- Delay line: PIPE-deep shift register of {hs0, vs0, active}, advanced only on ce. Outputs come from the last stage.
- Stage k means the value for the coordinates presented k ce-cycles earlier.
- Strobes are combinational: ce & ~rst & position match. Each is high for exactly one clk per event, even when ce is high continuously.
- Reset (any cycle, including mid-frame or mid-sync):
  - hc=0, vc=0.
  - All delay stages cleared to inactive: hsync=~HSYNC_POL, vsync=~VSYNC_POL, blank_n=0.
  - Strobes 0.
- After reset release:
  - The first ce cycle asserts frame_start and line_start.
  - The following PIPE-1 ce cycles keep outputs inactive.
  - Outputs are then valid.
- Boundaries:
  - Simultaneous line and frame wrap occurs at hc=799, vc=524 → 0,0.
  - vblank_start and frame_start never coincide.
- Timing: all counter/delay registers are in the clk domain, with no combinational path from ce to hc/vc.

Optional Feature:
- Macro: VTG_RGB_GATE_EN.
- Defined:
  - Adds inputs r_in, g_in, b_in (8 bits each, stage PIPE data from the renderer).
  - Adds outputs r, g, b (8 bits each).
  - On ce, r/g/b register rgb_in when the stage-PIPE blank is true, else register 0.
  - hsync/vsync/blank_n gain one extra stage (PIPE+1) so pins stay aligned with r/g/b.
  - Reset value of r, g, b is 0.
- Undefined: ports are absent and sync latency is exactly PIPE.

Test Plan:
- Reset with ce=1 for 3 clks, then release → hc=0, vc=0, frame_start=1 and line_start=1 on the first cycle; hsync=vsync=1 and blank_n=0 for the first PIPE=2 cycles.
- Free-run with ce=1 → line_start period 800 clks; frame_start period 420000 clks; vblank_start at vc=480, 384000 clks after frame_start.
- Horizontal decode → hsync=0 for exactly 96 ce-cycles, first low when hc=656+2 counted from stage 0; blank_n high for 640 cycles per visible line.
- Vertical decode → vsync low for exactly 1600 ce-cycles per frame (vc 490..491, delayed 2); blank_n never high on lines 480..524.
- ce toggling 1,0,0,1 pattern → counters and delay line advance only on ce; each strobe appears once per event; relative timing is preserved in ce-cycles.
- With VTG_RGB_GATE_EN and r_in=g_in=b_in=8'hFF constant → r/g/b=FF exactly while blank_n=1 and 0 otherwise; hsync falling edge 3 ce-cycles after hc=656.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: stage-0 pixel coordinates, line/frame strobes and PIPE-delayed sync/blank.
// Optional VTG_RGB_GATE_EN adds blank-gated r/g/b outputs with one extra aligning stage on sync/blank.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned PIPE      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
`ifdef VTG_RGB_GATE_EN
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
`endif
  output logic [9:0]  hc,
  output logic [9:0]  vc,
  output logic        active,
  output logic        line_start,
  output logic        frame_start,
  output logic        vblank_start,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // One delay-line entry: sync asserted flags (polarity applied at the pins) plus visibility.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } tstage_t;

  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  tstage_t       stage0;
  tstage_t       pipe_q [PIPE];
  tstage_t       pipe_d [PIPE];
  tstage_t       tap;

  // Raster counters: advance on ce only, line wrap carries into the line counter.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (ce) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        if (vc_q == V_LAST) begin
          vc_d = '0;
        end else begin
          vc_d = vc_q + CW'(1);
        end
      end else begin
        hc_d = hc_q + CW'(1);
      end
    end
  end

  always_comb begin
    stage0.hs  = (hc_q >= HS_BEG) && (hc_q <= HS_END);
    stage0.vs  = (vc_q >= VS_BEG) && (vc_q <= VS_END);
    stage0.act = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
  end

  // Delay line so sync/blank match a renderer with PIPE ce-cycles of latency.
  always_comb begin
    pipe_d = pipe_q;
    if (ce) begin
      pipe_d[0] = stage0;
      for (int k = 1; k < int'(PIPE); k++) begin
        pipe_d[k] = pipe_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q   <= '0;
      vc_q   <= '0;
      pipe_q <= '{default: '0};
    end else begin
      hc_q   <= hc_d;
      vc_q   <= vc_d;
      pipe_q <= pipe_d;
    end
  end

`ifdef VTG_RGB_GATE_EN
  tstage_t    out_q, out_d;
  logic [7:0] r_q, r_d;
  logic [7:0] g_q, g_d;
  logic [7:0] b_q, b_d;

  // Extra stage: colour is gated by the stage-PIPE blank and sync follows it by one ce.
  always_comb begin
    out_d = out_q;
    r_d   = r_q;
    g_d   = g_q;
    b_d   = b_q;
    if (ce) begin
      out_d = pipe_q[PIPE-1];
      if (pipe_q[PIPE-1].act) begin
        r_d = r_in;
        g_d = g_in;
        b_d = b_in;
      end else begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      out_q <= out_d;
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
    end
  end

  assign tap = out_q;
  assign r   = r_q;
  assign g   = g_q;
  assign b   = b_q;
`else
  assign tap = pipe_q[PIPE-1];
`endif

  assign hc           = hc_q;
  assign vc           = vc_q;
  assign active       = stage0.act;
  assign line_start   = ce & ~rst & (hc_q == '0);
  assign frame_start  = ce & ~rst & (hc_q == '0) & (vc_q == '0);
  assign vblank_start = ce & ~rst & (hc_q == '0) & (vc_q == V_ACT_C);
  assign hsync        = tap.hs ? HSYNC_POL : ~HSYNC_POL;
  assign vsync        = tap.vs ? VSYNC_POL : ~VSYNC_POL;
  assign blank_n      = tap.act;

endmodule
